// File: rtl/mem_port_arbiter.sv
// Two-requester (inst/data) arbiter onto one in-order memory port.
// Tracks the source of each accepted request in a small tag FIFO to route responses.
module mem_port_arbiter #(
  parameter int OUTST_DEPTH  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic [3:0]  outst_cnt,
  output logic        resp_err
);

  localparam int AW = $clog2(OUTST_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0]    DEPTH_C = 4'(OUTST_DEPTH);
  localparam logic [SW-1:0] SLIM    = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {UNLOCKED, LOCK_INST, LOCK_DATA} lock_e;

  lock_e                  lock_q, lock_d;
  logic [AW-1:0]          wp, rp;
  logic [OUTST_DEPTH-1:0] tag;
  logic [3:0]             cnt;
  logic [SW-1:0]          starve;
  logic                   err;

  logic own_data, sel_req, full, empty, accept, pop;
  cmd_t inst_cmd, data_cmd, mem_cmd;

  assign inst_cmd = '{inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
  assign data_cmd = '{data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};

  // A held lock pins ownership; otherwise starvation beats the default data priority.
  always_comb begin
    own_data = 1'b0;
    case (lock_q)
      LOCK_INST: own_data = 1'b0;
      LOCK_DATA: own_data = 1'b1;
      default: begin
        if (starve == SLIM && inst_sram_req) own_data = 1'b0;
        else                                 own_data = data_sram_req;
      end
    endcase
  end

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == 4'd0);
  assign sel_req = own_data ? data_sram_req : inst_sram_req;
  assign mem_req = sel_req & ~full & ~reset;
  assign accept  = mem_req & mem_addr_ok;
  assign pop     = mem_data_ok & ~empty & ~reset;

  assign mem_cmd   = own_data ? data_cmd : inst_cmd;
  assign mem_wr    = mem_cmd.wr;
  assign mem_size  = mem_cmd.size;
  assign mem_wstrb = mem_cmd.wstrb;
  assign mem_addr  = mem_cmd.addr;
  assign mem_wdata = mem_cmd.wdata;

  assign inst_sram_addr_ok = accept & ~own_data;
  assign data_sram_addr_ok = accept &  own_data;
  assign inst_sram_data_ok = pop & ~tag[rp];
  assign data_sram_data_ok = pop &  tag[rp];
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  assign outst_cnt = cnt;
  assign resp_err  = err;

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      UNLOCKED: if (mem_req && !mem_addr_ok) lock_d = own_data ? LOCK_DATA : LOCK_INST;
      default:  if (accept) lock_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= UNLOCKED;
      wp     <= '0;
      rp     <= '0;
      tag    <= '0;
      cnt    <= '0;
      starve <= '0;
      err    <= 1'b0;
    end else begin
      lock_q <= lock_d;
      if (accept) begin
        tag[wp] <= own_data;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
      if (mem_data_ok && empty) err <= 1'b1;
      // Saturating count of data wins that left inst waiting.
      if (accept && own_data && inst_sram_req) begin
        if (starve != SLIM) starve <= starve + 1'b1;
      end else if ((accept && !own_data) || !inst_sram_req) begin
        starve <= '0;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: OUTST_DEPTH, default 4, maximum accepted-but-unanswered requests (power of two, 2..8).
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive data grants with inst pending before inst is forced.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_sram_req/wr  in  1 each; inst_sram_size  in  2; inst_sram_wstrb  in  4; inst_sram_addr/wdata  in  32 each: instruction requester command.
REQ-006 inst_sram_addr_ok/data_ok  out  1 each; inst_sram_rdata  out  32: instruction requester response.
REQ-007 data_sram_req/wr/size/wstrb/addr/wdata  in  same widths as REQ-005: data requester command.
REQ-008 data_sram_addr_ok/data_ok  out  1 each; data_sram_rdata  out  32: data requester response.
REQ-009 mem_req/wr  out  1 each; mem_size  out  2; mem_wstrb  out  4; mem_addr/wdata  out  32 each: shared downstream port command.
REQ-010 mem_addr_ok/data_ok  in  1 each; mem_rdata  in  32: downstream response, returned strictly in acceptance order.
REQ-011 outst_cnt  out  4  current outstanding request count.
REQ-012 resp_err  out  1  sticky: data_ok received with no outstanding request.

Function
REQ-013 Grant is combinational: owner = lock owner if locked; else data if data_sram_req; else inst if inst_sram_req; starvation override (REQ-018) takes precedence over data when unlocked.
REQ-014 mem_req = selected requester's req AND outst_cnt < OUTST_DEPTH; mem_wr/size/wstrb/addr/wdata are muxed from the owner (inst when no owner).
REQ-015 Owner's addr_ok = mem_addr_ok AND mem_req; non-owner's addr_ok = 0 in the same cycle.
REQ-016 Lock FSM: UNLOCKED -> LOCK_INST/LOCK_DATA when mem_req=1 and mem_addr_ok=0; locked -> UNLOCKED on the cycle mem_req & mem_addr_ok; ownership never changes while a request is offered but not accepted.
REQ-017 Order FIFO: depth OUTST_DEPTH, 1-bit source tag (0 inst, 1 data); push on mem_req & mem_addr_ok; pop on mem_data_ok when non-empty; push and pop in the same cycle leave the count unchanged.
REQ-018 Starvation counter: increments on each accepted data request while inst_sram_req=1; clears on an accepted inst request or when inst_sram_req=0; at STARVE_LIMIT the next unlocked grant goes to inst.
REQ-019 mem_data_ok routed by FIFO head: head=0 -> inst_sram_data_ok, head=1 -> data_sram_data_ok, same cycle, zero latency; the other data_ok = 0.
REQ-020 mem_rdata drives both inst_sram_rdata and data_sram_rdata unchanged.
REQ-021 Full: when outst_cnt = OUTST_DEPTH, mem_req = 0 and no addr_ok is asserted, even if a pop occurs that cycle (no bypass).
REQ-022 Empty: mem_data_ok with outst_cnt = 0 sets resp_err, asserts no data_ok, and leaves FIFO state unchanged.
REQ-023 outst_cnt is registered and equals FIFO occupancy; pointers wrap modulo OUTST_DEPTH.

Reset
REQ-024 Reset clears lock state to UNLOCKED, FIFO pointers, outst_cnt and starvation counter to 0, and resp_err to 0.
REQ-025 While reset=1, mem_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok and data_sram_data_ok are 0.
REQ-026 Reset asserted mid-transaction discards all outstanding tags; mem_data_ok arriving after reset deasserts with outst_cnt=0 sets resp_err.

Verification
REQ-027 Both req=1 at 0x1c000000 (inst) and 0x00001000 (data), mem_addr_ok=1 -> mem_addr=0x00001000, data_sram_addr_ok=1, inst_sram_addr_ok=0.
REQ-028 Inst req alone, mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays the inst address until accepted; data is granted the cycle after.
REQ-029 Accept inst, data, inst; return three mem_data_ok pulses -> data_ok order inst, data, inst; outst_cnt sequence 3,2,1,0.
REQ-030 Four accepted, mem_addr_ok held 1 -> mem_req=0, outst_cnt=4; one mem_data_ok -> mem_req=1 the following cycle.
REQ-031 Both req held continuously, mem_addr_ok=1 -> four data grants, then one inst grant, pattern repeats.
REQ-032 mem_data_ok with outst_cnt=0 -> resp_err=1, held until reset; both data_ok remain 0.
